// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends one command byte with
// odd parity on device clock edges, then reports ACK, ACK error or timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES     = 5000,
  parameter int FIRST_EDGE_TIMEOUT = 750000,
  parameter int PACKET_TIMEOUT     = 100000,
  parameter int SYNC_STAGES        = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack_err,
  output logic       tx_timeout
);

  localparam int MAX_AB  = (INHIBIT_CYCLES > FIRST_EDGE_TIMEOUT) ? INHIBIT_CYCLES : FIRST_EDGE_TIMEOUT;
  localparam int MAX_CNT = (MAX_AB > PACKET_TIMEOUT) ? MAX_AB : PACKET_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int SYNC_W  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] FIRST_LAST = CNT_W'(FIRST_EDGE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PKT_LAST   = CNT_W'(PACKET_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_INHIBIT    = 3'd1,
    ST_WAIT_FIRST = 3'd2,
    ST_SEND       = 3'd3,
    ST_WAIT_IDLE  = 3'd4,
    ST_FINISH     = 3'd5
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s, cnt_inc_s;
  logic [3:0]         edge_cnt_r, edge_cnt_s;
  logic [8:0]         shift_r, shift_s;
  logic               ack_err_r, ack_err_s;
  logic [SYNC_W-1:0]  clk_sync_r, dat_sync_r;
  logic               clk_prev_r;
  logic               clk_s, dat_s, fe_s;
  logic               clk_oe_r, clk_oe_s;
  logic               dat_oe_r, dat_oe_s;
  logic               tx_ready_r, busy_r;
  logic               done_r, done_s;
  logic               err_r, err_s;
  logic               to_r, to_s;

  assign clk_s     = clk_sync_r[SYNC_W-1];
  assign dat_s     = dat_sync_r[SYNC_W-1];
  assign fe_s      = clk_prev_r & ~clk_s;
  assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_W'(1));

  // Next-state, counter, shift register and line-enable decode
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    edge_cnt_s = edge_cnt_r;
    shift_s    = shift_r;
    ack_err_s  = ack_err_r;
    clk_oe_s   = 1'b0;
    dat_oe_s   = dat_oe_r;
    done_s     = 1'b0;
    err_s      = 1'b0;
    to_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        dat_oe_s = 1'b0;
        if (tx_valid && tx_ready_r) begin
          state_s    = ST_INHIBIT;
          shift_s    = {odd_parity(tx_data), tx_data};
          cnt_s      = CNT_ZERO;
          edge_cnt_s = 4'd0;
          ack_err_s  = 1'b0;
          clk_oe_s   = 1'b1;
          dat_oe_s   = (INH_LAST == CNT_ZERO);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_INHIBIT: begin
        // Start bit goes out on the final inhibit cycle so data is low at release
        if (cnt_r >= INH_LAST) begin
          state_s  = ST_WAIT_FIRST;
          cnt_s    = CNT_ZERO;
          clk_oe_s = 1'b0;
          dat_oe_s = 1'b1;
        end else begin
          cnt_s    = cnt_inc_s;
          clk_oe_s = 1'b1;
          dat_oe_s = (cnt_inc_s >= INH_LAST);
        end
      end
      ST_WAIT_FIRST: begin
        dat_oe_s = 1'b1;
        if (cnt_r >= FIRST_LAST) begin
          state_s  = ST_FINISH;
          to_s     = 1'b1;
          dat_oe_s = 1'b0;
          cnt_s    = CNT_ZERO;
        end else if (fe_s) begin
          state_s    = ST_SEND;
          dat_oe_s   = ~shift_r[0];
          shift_s    = {1'b0, shift_r[8:1]};
          edge_cnt_s = 4'd1;
          cnt_s      = CNT_ZERO;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      ST_SEND: begin
        if (cnt_r >= PKT_LAST) begin
          state_s  = ST_FINISH;
          to_s     = 1'b1;
          dat_oe_s = 1'b0;
          cnt_s    = CNT_ZERO;
        end else if (fe_s) begin
          cnt_s = cnt_inc_s;
          if (edge_cnt_r >= 4'd10) begin
            state_s    = ST_WAIT_IDLE;
            edge_cnt_s = 4'd11;
            ack_err_s  = dat_s;
            dat_oe_s   = 1'b0;
          end else if (edge_cnt_r == 4'd9) begin
            edge_cnt_s = 4'd10;
            dat_oe_s   = 1'b0;
          end else begin
            edge_cnt_s = edge_cnt_r + 4'd1;
            dat_oe_s   = ~shift_r[0];
            shift_s    = {1'b0, shift_r[8:1]};
          end
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      ST_WAIT_IDLE: begin
        dat_oe_s = 1'b0;
        if (cnt_r >= PKT_LAST) begin
          state_s = ST_FINISH;
          to_s    = 1'b1;
          cnt_s   = CNT_ZERO;
        end else if (clk_s && dat_s) begin
          state_s = ST_FINISH;
          done_s  = ~ack_err_r;
          err_s   = ack_err_r;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      ST_FINISH: begin
        dat_oe_s = 1'b0;
        cnt_s    = CNT_ZERO;
        state_s  = ST_IDLE;
      end
      default: begin
        dat_oe_s = 1'b0;
        cnt_s    = CNT_ZERO;
        state_s  = ST_IDLE;
      end
    endcase
  end

  // State, datapath, synchronizer and registered output update
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      edge_cnt_r <= 4'd0;
      shift_r    <= 9'd0;
      ack_err_r  <= 1'b0;
      clk_sync_r <= {SYNC_W{1'b1}};
      dat_sync_r <= {SYNC_W{1'b1}};
      clk_prev_r <= 1'b1;
      clk_oe_r   <= 1'b0;
      dat_oe_r   <= 1'b0;
      tx_ready_r <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      to_r       <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      edge_cnt_r <= edge_cnt_s;
      shift_r    <= shift_s;
      ack_err_r  <= ack_err_s;
      clk_sync_r <= {clk_sync_r[SYNC_W-2:0], ps2_clk_in};
      dat_sync_r <= {dat_sync_r[SYNC_W-2:0], ps2_dat_in};
      clk_prev_r <= clk_s;
      clk_oe_r   <= clk_oe_s;
      dat_oe_r   <= dat_oe_s;
      tx_ready_r <= (state_s == ST_IDLE);
      busy_r     <= (state_s != ST_IDLE);
      done_r     <= done_s;
      err_r      <= err_s;
      to_r       <= to_s;
    end
  end

  assign tx_ready   = tx_ready_r;
  assign busy       = busy_r;
  assign ps2_clk_oe = clk_oe_r;
  assign ps2_dat_oe = dat_oe_r;
  assign tx_done    = done_r;
  assign tx_ack_err = err_r;
  assign tx_timeout = to_r;

endmodule
